// File: rtl/tk_dmem_responder_pkg.sv
// Shared types and address-split widths for the ThreadKraken data-memory responder.
package tk_mem_pkg;

    localparam int unsigned MEM_WORDS_DEF  = 1024;
    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned NUM_LINES_DEF  = 16;
    localparam int unsigned FILL_LAT_DEF   = 8;

    localparam int unsigned TRD_BITS      = 3;
    localparam int unsigned LINE_OFS_BITS = $clog2(LINE_WORDS_DEF);
    localparam int unsigned IDX_BITS      = $clog2(NUM_LINES_DEF);
    // Tag is everything above the line index within the 30-bit word address.
    localparam int unsigned TAG_BITS      = 30 - LINE_OFS_BITS - IDX_BITS;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_BITS-1:0] index;
        logic [TAG_BITS-1:0] tag;
        logic [TRD_BITS-1:0] trd;
    } fill_req_t;

endpackage

// File: rtl/tk_dmem_responder_if.sv
// Core-side d_* load/store bus plus fill-completion wakeup signals.
interface tk_dmem_responder_if;
    import tk_mem_pkg::*;

    logic [31:0]         d_addr;
    logic [31:0]         d_wr_data;
    logic                d_rd;
    logic                d_wr;
    logic [TRD_BITS-1:0] d_trd;
    logic [31:0]         d_rd_data;
    logic                d_miss;
    logic                d_segfault;
    logic                fill_done;
    logic [TRD_BITS-1:0] fill_trd;
    logic                busy;

    modport master (
        output d_addr, d_wr_data, d_rd, d_wr, d_trd,
        input  d_rd_data, d_miss, d_segfault, fill_done, fill_trd, busy
    );

    modport slave (
        input  d_addr, d_wr_data, d_rd, d_wr, d_trd,
        output d_rd_data, d_miss, d_segfault, fill_done, fill_trd, busy
    );

endinterface

// File: rtl/tk_dmem_responder_line_tracker.sv
// Direct-mapped line-presence tracker: valid bits and tags with one lookup and one set port.
module tk_line_tracker
    import tk_mem_pkg::*;
#(
    parameter int unsigned NUM_LINES = NUM_LINES_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IDX_BITS-1:0] lk_index_i,
    input  logic [TAG_BITS-1:0] lk_tag_i,
    output logic                hit_o,
    input  logic                set_en_i,
    input  logic [IDX_BITS-1:0] set_index_i,
    input  logic [TAG_BITS-1:0] set_tag_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_BITS-1:0]  tag_q [NUM_LINES];

    // Valid bits: cleared by reset, set when a fill completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (set_en_i) begin
            valid_q[set_index_i] <= 1'b1;
        end
    end

    // Tags are meaningless while their valid bit is clear, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (set_en_i) begin
            tag_q[set_index_i] <= set_tag_i;
        end
    end

    assign hit_o = valid_q[lk_index_i] && (tag_q[lk_index_i] == lk_tag_i);

endmodule

// File: rtl/tk_dmem_responder.sv
// Memory-side end of the core's d_* interface: word array, segfault detection,
// miss tracking and a single fixed-latency fill engine with per-thread wakeup.
module tk_dmem_responder
    import tk_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = MEM_WORDS_DEF,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned NUM_LINES  = NUM_LINES_DEF,
    parameter int unsigned FILL_LAT   = FILL_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    tk_dmem_responder_if.slave dmem
);

    localparam int unsigned WA_BITS  = $clog2(MEM_WORDS);
    localparam int unsigned LO_BITS  = $clog2(LINE_WORDS);
    localparam int unsigned CNT_BITS = $clog2(FILL_LAT + 1);

    logic [31:0]         mem_q [MEM_WORDS];
    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    fill_req_t           req_q, req_d;
    logic                fill_done_q;
    logic [TRD_BITS-1:0] fill_trd_q;

    logic                req_s, seg_s, legal_s, hit_s, miss_s, wr_en_s, set_en_s;
    logic [WA_BITS-1:0]  widx_s;
    logic [IDX_BITS-1:0] idx_s;
    logic [TAG_BITS-1:0] tag_s;

    assign widx_s = dmem.d_addr[2 +: WA_BITS];
    assign idx_s  = dmem.d_addr[2 + LO_BITS +: IDX_BITS];
    assign tag_s  = dmem.d_addr[31 -: TAG_BITS];

    assign req_s   = dmem.d_rd | dmem.d_wr;
    assign seg_s   = req_s & ((dmem.d_addr[1:0] != 2'b00) |
                              (dmem.d_addr >= 32'(MEM_WORDS * 4)) |
                              (dmem.d_rd & dmem.d_wr));
    assign legal_s = req_s & ~seg_s;
    assign miss_s  = legal_s & ~hit_s;
    assign wr_en_s = legal_s & dmem.d_wr & hit_s;

    tk_line_tracker #(
        .NUM_LINES (NUM_LINES)
    ) u_tracker (
        .clk_i       (clk),
        .rst_i       (rst),
        .lk_index_i  (idx_s),
        .lk_tag_i    (tag_s),
        .hit_o       (hit_s),
        .set_en_i    (set_en_s),
        .set_index_i (req_d.index),
        .set_tag_i   (req_d.tag)
    );

    // Store hits update the backing array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[widx_s] <= dmem.d_wr_data;
        end
    end

    // Fill FSM next state; completion is flagged on the edge that loads a count of one,
    // which also covers a one-cycle fill started directly from IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (miss_s) begin
                    state_d = FILL;
                    cnt_d   = CNT_BITS'(FILL_LAT);
                    req_d   = '{index: idx_s, tag: tag_s, trd: dmem.d_trd};
                end else begin
                    cnt_d   = {CNT_BITS{1'b0}};
                end
            end
            FILL: begin
                if (cnt_q == CNT_BITS'(1)) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_BITS{1'b0}};
                end else begin
                    cnt_d   = cnt_q - CNT_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_BITS{1'b0}};
            end
        endcase
        set_en_s = (state_d == FILL) && (cnt_d == CNT_BITS'(1));
    end

    // FSM, fill request and completion pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_BITS{1'b0}};
            req_q       <= '0;
            fill_done_q <= 1'b0;
            fill_trd_q  <= {TRD_BITS{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            fill_done_q <= set_en_s;
            fill_trd_q  <= set_en_s ? req_d.trd : fill_trd_q;
        end
    end

    assign dmem.d_rd_data  = (legal_s & dmem.d_rd & hit_s) ? mem_q[widx_s] : 32'h0000_0000;
    assign dmem.d_miss     = miss_s;
    assign dmem.d_segfault = seg_s;
    assign dmem.fill_done  = fill_done_q;
    assign dmem.fill_trd   = fill_trd_q;
    assign dmem.busy       = (state_q == FILL);

endmodule

// File: doc/tk_dmem_responder.md
# tk_dmem_responder

Synthesizable data-memory responder for the ThreadKraken core: the memory-side end of the `d_*` load/store interface that the core initiates. It serves word loads/stores from a local array, models cache misses with a direct-mapped line-presence tracker and a fixed-latency fill engine, and flags segmentation faults. It also reports fill completion per thread so the core can wake the sleeping requester.

## Interface
- `MEM_WORDS`, 1024: backing array depth in 32-bit words; power of two.
- `LINE_WORDS`, 4: words per line; power of two.
- `NUM_LINES`, 16: tracker entries; power of two.
- `FILL_LAT`, 8: cycles from miss to line present; ≥ 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `d_addr` in 32: byte address.
- `d_wr_data` in 32: store data.
- `d_rd` in 1: load request, one cycle per attempt.
- `d_wr` in 1: store request, one cycle per attempt.
- `d_trd` in 3: requesting thread ID.
- `d_rd_data` out 32: load data, combinational.
- `d_miss` out 1: request not serviced, line absent; combinational.
- `d_segfault` out 1: illegal request; combinational.
- `fill_done` out 1: registered one-cycle pulse when a fill completes.
- `fill_trd` out 3: thread that triggered the completed fill; valid with `fill_done`.
- `busy` out 1: fill engine active.

## Operation
- **Request.** A request is a cycle with `d_rd | d_wr`. There is no handshake; the responder answers in the same cycle.
- **Segfault.** `d_segfault` = req & (addr[1:0] != 0 | addr ≥ MEM_WORDS*4 | (d_rd & d_wr)). On segfault: `d_miss` = 0, no array access, no fill started.
- **Address split.** Word = addr[31:2]. Line = word / LINE_WORDS. Index = line mod NUM_LINES. Tag = line / NUM_LINES.
- **Hit.** Hit = valid[index] & tag match.
  - Load hit: `d_rd_data` = mem[word].
  - Store hit: mem[word] ← `d_wr_data` at the clock edge.
- **Outputs when not a load hit.** `d_rd_data` = 0 whenever the cycle is not a load hit.
- **Miss.** Legal request that is not a hit: `d_miss` = 1, no array write.
  - If FSM is IDLE, the miss starts a fill. It latches index, tag and `d_trd`, and loads counter = FILL_LAT.
- **Misses while filling.**
  - Same line as the fill in progress: `d_miss` = 1, no new fill.
  - Different line: `d_miss` = 1, request dropped; the requester retries.
- **FSM, two states.**
  - IDLE → FILL on a legal miss.
  - FILL: counter decrements each cycle. When counter reaches 1 at an edge, set valid[index] and write the tag, pulse `fill_done` with `fill_trd`, and go to IDLE.
  - The fill evicts any previous line at that index. There is no writeback; array data stays authoritative.
- **`busy`** = (state == FILL).
- **Reset.** Asserting `rst` clears all valid bits, FSM → IDLE, counter = 0, `fill_done` = 0, `fill_trd` = 0.
  - Array contents are not reset; they are preloaded via `$readmemh` in simulation.
  - Reset mid-fill aborts the fill: no `fill_done`, line stays absent.

## Timing
- **Load latency.** Hit data is combinational in the request cycle N.
- **Store.** The store is visible to a load in cycle N+1.
- **Fill timing.** Miss in cycle N → `fill_done` high in cycle N+FILL_LAT, for exactly one cycle. The line hits from cycle N+FILL_LAT.
- **FILL_LAT = 1.** `fill_done` occurs in cycle N+1 and `busy` is high only during N+1.
- **New miss on the completion edge.** A miss in the same cycle as `fill_done` sees IDLE next cycle. It is dropped, not queued; a fresh miss starts a new fill from N+FILL_LAT+1 onward.
- **Outputs after reset release.** `d_miss` = 0, `d_segfault` = 0, `d_rd_data` = 0 while there is no request.

## Structure
- **Package `tk_mem_pkg`:**
  - state enum {IDLE, FILL};
  - address-split field-width localparams derived from the parameters;
  - fill-request struct {index, tag, trd}.
- **Sub-module `tk_line_tracker`:** valid and tag arrays.
  - Combinational lookup port (index, tag → hit).
  - One set port (index, tag) and async clear on `rst`.
- **Top level:** the array, segfault logic and fill FSM.

## Test plan
- **Cold load, then warm load.** Cold load at 0x40 by thread 3 → `d_miss` = 1, `busy` from next cycle. `fill_done` = 1 with `fill_trd` = 3 exactly 8 cycles later. A retried load in that cycle hits with mem[0x10].
- **Store round trip.** With the line at 0x40 present, store 0xDEADBEEF to 0x44, then load 0x44 next cycle → 0xDEADBEEF, `d_miss` = 0.
- **Segfault cases.** Each of the following → `d_segfault` = 1, `d_miss` = 0, `busy` stays 0:
  - load at 0x2;
  - load at 0x1000 (MEM_WORDS = 1024);
  - `d_rd` and `d_wr` together.
- **Conflicting miss during a fill.** During the fill for 0x40, a miss to 0x80 by thread 5 → `d_miss` = 1 and only one `fill_done` (`fill_trd` = 3). 0x80 still misses afterward.
- **Eviction.** Fill 0x40, then fill 0x440 (same index, different tag) → a subsequent load at 0x40 misses again.
- **Reset mid-fill.** Assert `rst` at cycle 4 of a fill → no `fill_done`, `busy` = 0 immediately, and the line still misses after release.
